// File: rtl/reg_pipe_pkg.sv
// Shared defaults and sizing helper for the reg_pipe pipeline register.
package reg_pipe_pkg;

  localparam int REG_PIPE_WIDTH  = 12;
  localparam int REG_PIPE_STAGES = 2;

  // Bits needed to count 0..2*stages held words.
  function automatic int occ_width(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/reg_slice.sv
// One skid-buffered register slice: a main entry plus a skid entry, with a
// registered ready so no combinational ready path crosses the slice.
module reg_slice #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  output logic             dn_valid,
  output logic [WIDTH-1:0] dn_data,
  input  logic             dn_ready
);

  logic             main_valid;
  logic             skid_valid;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset too so out_data reads 0 out of reset.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (clr) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (dn_ready || !main_valid) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= up_valid;
        main_data  <= up_data;
      end
    end else if (up_valid && !skid_valid) begin
      // Main is stalled: park the word that was accepted this edge.
      skid_valid <= 1'b1;
      skid_data  <= up_data;
    end
  end

  assign up_ready = !skid_valid;
  assign dn_valid = main_valid;
  assign dn_data  = main_data;

endmodule

// File: rtl/reg_pipe.sv
// Back-pressured pipeline register: STAGES chained skid slices, a synchronous
// flush and a live count of held words.
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter  int WIDTH  = REG_PIPE_WIDTH,
  parameter  int STAGES = REG_PIPE_STAGES,
  localparam int CW     = occ_width(STAGES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    occupancy
);

  // Link i feeds slice i; link STAGES is the block output.
  logic [STAGES:0] link_valid;
  logic [STAGES:0] link_ready;
  logic [WIDTH-1:0] link_data [STAGES+1];

  assign link_valid[0]      = in_valid;
  assign link_data[0]       = in_data;
  assign link_ready[STAGES] = out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_slice
    reg_slice #(.WIDTH(WIDTH)) u_slice (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .up_valid (link_valid[i]),
      .up_data  (link_data[i]),
      .up_ready (link_ready[i]),
      .dn_valid (link_valid[i+1]),
      .dn_data  (link_data[i+1]),
      .dn_ready (link_ready[i+1])
    );
  end

  // A flush cycle never accepts a word, so the count can simply drop to 0.
  assign in_ready  = link_ready[0] && !clr;
  assign out_valid = link_valid[STAGES];
  assign out_data  = link_data[STAGES];

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else if (clr) begin
      occupancy <= '0;
    end else begin
      case ({in_fire, out_fire})
        2'b10:   occupancy <= occupancy + CW'(1);
        2'b01:   occupancy <= occupancy - CW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_pipe.sv
// Scoreboard bench for reg_pipe: the monitor pushes accepted words and pops
// and compares on every output transfer, independent of the stimulus.
module tb_reg_pipe;
  import reg_pipe_pkg::*;

  localparam int WIDTH  = 12;
  localparam int STAGES = 2;
  localparam int CW     = occ_width(STAGES);

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    occupancy;

  reg_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int               n_checks = 0;
  int               n_fail   = 0;
  int               out_cnt  = 0;
  bit               mon_en   = 1'b0;
  logic [WIDTH-1:0] sb [$];
  logic [WIDTH-1:0] exp_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sampled mid-cycle, describing the transfers of the coming edge.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check("occupancy_vs_sb", 32'(occupancy), 32'(sb.size()));
      if (out_valid && out_ready) begin
        check("sb_nonempty_on_out", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_word = sb.pop_front();
          check("out_data", 32'(out_data), 32'(exp_word));
        end
        out_cnt++;
      end
      if (in_valid && in_ready) sb.push_back(in_data);
      if (clr) sb.delete();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int peak;
    int acc;
    bit fire;

    // Reset with a word offered: it must be ignored.
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b1; in_data = 12'h5A5; out_ready = 1'b0;
    repeat (3) step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_occupancy", 32'(occupancy), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_data", 32'(out_data), 32'd0);
    mon_en = 1'b1;
    step();

    // Streaming 0x001..0x00A with out_ready held high.
    base = out_cnt; peak = 0;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 12'h001;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (int'(occupancy) > peak) peak = int'(occupancy);
      if (e == 1) check("latency_edge1_out_valid", 32'(out_valid), 32'd0);
      if (e == 2) begin
        check("latency_edge2_out_valid", 32'(out_valid), 32'd1);
        check("first_word", 32'(out_data), 32'h001);
      end
      if (e == 11) check("stream_count_edge11", 32'(out_cnt - base), 32'd9);
      if (e < 10) in_data = WIDTH'(e + 1);
      else in_valid = 1'b0;
    end
    check("stream_count_total", 32'(out_cnt - base), 32'd10);
    check("stream_peak_occupancy", 32'(peak), 32'd2);

    // Stall fill: exactly 2*STAGES words fit.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 12'h100; acc = 0;
    for (int e = 0; e < 8; e++) begin
      fire = in_ready;
      step();
      if (fire) begin
        acc++;
        in_data = in_data + 1'b1;
      end
    end
    check("stall_accepted", 32'(acc), 32'd4);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_occupancy", 32'(occupancy), 32'd4);
    check("stall_head", 32'(out_data), 32'h100);

    // Drain: in_ready comes back once the first slice's skid empties.
    in_valid = 1'b0; out_ready = 1'b1; base = out_cnt;
    step();
    check("release_edge1_in_ready", 32'(in_ready), 32'd0);
    step();
    check("release_edge2_in_ready", 32'(in_ready), 32'd1);
    for (int e = 0; e < 10 && occupancy != 0; e++) step();
    check("drain_occupancy", 32'(occupancy), 32'd0);
    check("drain_count", 32'(out_cnt - base), 32'd4);

    // Flush with three words held while a fourth is offered.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 12'h200;
    repeat (3) begin
      step();
      in_data = in_data + 1'b1;
    end
    check("flush_pre_occupancy", 32'(occupancy), 32'd3);
    in_data = 12'hBAD; clr = 1'b1;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    clr = 1'b0; in_valid = 1'b0;
    check("flush_occupancy", 32'(occupancy), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    base = out_cnt; out_ready = 1'b1;
    repeat (5) step();
    check("flush_no_output", 32'(out_cnt - base), 32'd0);

    // Random handshakes; the monitor checks order and occupancy every cycle.
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = WIDTH'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int e = 0; e < 10 && occupancy != 0; e++) step();
    check("random_drain_occupancy", 32'(occupancy), 32'd0);
    check("random_drain_sb_empty", 32'(sb.size()), 32'd0);

    // Asynchronous reset between edges with the pipe full.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 12'h300;
    repeat (6) begin
      step();
      in_data = in_data + 1'b1;
    end
    check("areset_pre_occupancy", 32'(occupancy), 32'd4);
    in_valid = 1'b0;
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("areset_out_valid", 32'(out_valid), 32'd0);
    check("areset_occupancy", 32'(occupancy), 32'd0);
    check("areset_out_data", 32'(out_data), 32'd0);
    sb.delete();
    step();
    rst_n = 1'b1;
    #1;
    mon_en = 1'b1;

    // One word after reset must pass straight through.
    base = out_cnt; out_ready = 1'b1; in_valid = 1'b1; in_data = 12'h3C3;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    check("post_reset_count", 32'(out_cnt - base), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
